// File: rtl/mod_inverse.sv
// Modular inverse by binary extended Euclid: shift/add/subtract only, one reduction step per cycle.
// Result x satisfies (a*x) mod m == 1; error flags illegal operands or gcd(a,m) > 1.
module mod_inverse #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] modulant,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ONE_W  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH:0]   ONE_X  = {{DATA_WIDTH{1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH:0]   ZERO_X = {(DATA_WIDTH+1){1'b0}};

  state_t                state_r;
  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] m_r;
  logic [DATA_WIDTH-1:0] u_r;
  logic [DATA_WIDTH-1:0] v_r;
  logic [DATA_WIDTH:0]   x1_r;
  logic [DATA_WIDTH:0]   x2_r;
  logic                  illegal_s;

  // Halve x modulo odd m; x+m stays below 2m so the extra bit is enough.
  function automatic logic [DATA_WIDTH:0] half_mod(
    input logic [DATA_WIDTH:0]   x,
    input logic [DATA_WIDTH-1:0] m
  );
    logic [DATA_WIDTH:0] sum;
    sum = x + {1'b0, m};
    if (x[0]) begin
      half_mod = sum >> 1;
    end else begin
      half_mod = x >> 1;
    end
  endfunction

  // (p - q) mod m for p, q already in 0..m-1.
  function automatic logic [DATA_WIDTH:0] sub_mod(
    input logic [DATA_WIDTH:0]   p,
    input logic [DATA_WIDTH:0]   q,
    input logic [DATA_WIDTH-1:0] m
  );
    if (p >= q) begin
      sub_mod = p - q;
    end else begin
      sub_mod = p + {1'b0, m} - q;
    end
  endfunction

  // Operand legality, evaluated on the latched values during LOAD.
  always_comb begin
    illegal_s = 1'b0;
    if ((m_r[0] == 1'b0) || (m_r <= ONE_W) || (a_r == '0) || (a_r >= m_r)) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = 1'b0;
    end
  end

  // Control FSM and datapath; outputs are registered and only move on DONE entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      a_r     <= '0;
      m_r     <= '0;
      u_r     <= '0;
      v_r     <= '0;
      x1_r    <= '0;
      x2_r    <= '0;
      out     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            a_r     <= a;
            m_r     <= modulant;
            done    <= 1'b0;
            error   <= 1'b0;
            busy    <= 1'b1;
            state_r <= LOAD;
          end
        end
        LOAD: begin
          if (illegal_s) begin
            out     <= '0;
            error   <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end else begin
            u_r     <= a_r;
            v_r     <= m_r;
            x1_r    <= ONE_X;
            x2_r    <= ZERO_X;
            state_r <= RUN;
          end
        end
        RUN: begin
          if (u_r == ONE_W) begin
            out     <= x1_r[DATA_WIDTH-1:0];
            error   <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end else if (v_r == ONE_W) begin
            out     <= x2_r[DATA_WIDTH-1:0];
            error   <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end else if ((u_r == '0) || (v_r == '0)) begin
            // u and v converged to a common factor above 1
            out     <= '0;
            error   <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end else if (!u_r[0]) begin
            u_r  <= u_r >> 1;
            x1_r <= half_mod(x1_r, m_r);
          end else if (!v_r[0]) begin
            v_r  <= v_r >> 1;
            x2_r <= half_mod(x2_r, m_r);
          end else if (u_r >= v_r) begin
            u_r  <= u_r - v_r;
            x1_r <= sub_mod(x1_r, x2_r, m_r);
          end else begin
            v_r  <= v_r - u_r;
            x2_r <= sub_mod(x2_r, x1_r, m_r);
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  mod_inverse_checker #(.DATA_WIDTH(DATA_WIDTH)) u_checker (
    .clock   (clock),
    .reset_n (reset_n),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .out     (out),
    .m       (m_r)
  );

endmodule

// Output consistency properties for mod_inverse.
module mod_inverse_checker #(
  parameter int DATA_WIDTH = 8
) (
  input logic                  clock,
  input logic                  reset_n,
  input logic                  busy,
  input logic                  done,
  input logic                  error,
  input logic [DATA_WIDTH-1:0] out,
  input logic [DATA_WIDTH-1:0] m
);

  // busy and done are exclusive; a finished result is reduced or zero on error.
  always @(posedge clock) begin
    if (reset_n) begin
      assert (!(busy && done)) else $error("mod_inverse: busy and done both high");
      if (done && error) begin
        assert (out == '0) else $error("mod_inverse: nonzero out with error");
      end
      if (done && !error) begin
        assert (out < m) else $error("mod_inverse: out not reduced below m");
      end
    end
  end

endmodule

// File: tb/tb_mod_inverse.sv
// Directed bench for mod_inverse (DATA_WIDTH=8): hand-computed vectors plus a gcd-based sweep.
module tb_mod_inverse;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] m_in;
  logic [7:0] out;
  logic       busy;
  logic       done;
  logic       error;

  int checks;
  int errors;

  mod_inverse #(.DATA_WIDTH(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .a        (a_in),
    .modulant (m_in),
    .out      (out),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int gcd(input int x, input int y);
    int p;
    int q;
    int t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Issue one start, scramble the operand inputs afterwards, and wait for done.
  task automatic run(input logic [7:0] ta, input logic [7:0] tm,
                     output logic [7:0] res, output logic er, output int lat);
    logic got;
    @(negedge clock);
    start = 1'b1;
    a_in  = ta;
    m_in  = tm;
    @(posedge clock);
    #1;
    start = 1'b0;
    a_in  = ~ta;
    m_in  = tm ^ 8'h5A;
    chk("accept_busy", busy, 1);
    chk("accept_done", done, 0);
    chk("accept_err", error, 0);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
      if (done) got = 1'b1;
    end
    chk("done_seen", got, 1);
    res = out;
    er  = error;
  endtask

  logic [7:0] res;
  logic       er;
  int         lat;
  logic       got;

  typedef struct { int a; int m; } vec_t;
  vec_t bad_vecs[5];
  int   sweep_m[3];

  initial begin
    checks  = 0;
    errors  = 0;
    start   = 1'b0;
    a_in    = 8'd0;
    m_in    = 8'd0;
    reset_n = 1'b0;
    #22;
    chk("rst_out", out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // First start after reset is taken; 3^-1 mod 7 = 5
    run(8'd3, 8'd7, res, er, lat);
    chk("inv_3_7", res, 5);
    chk("err_3_7", er, 0);
    chk("lat_3_7", (lat <= 34), 1);

    // Result and flags hold while idle in DONE
    repeat (3) @(posedge clock);
    #1;
    chk("hold_done", done, 1);
    chk("hold_out", out, 5);
    chk("hold_busy", busy, 0);

    run(8'd7, 8'd255, res, er, lat);
    chk("inv_7_255", res, 73);
    chk("err_7_255", er, 0);
    chk("lat_7_255", (lat <= 34), 1);

    // a=1 ends on the first RUN cycle: LOAD, RUN, DONE
    run(8'd1, 8'd13, res, er, lat);
    chk("inv_1_13", res, 1);
    chk("err_1_13", er, 0);
    chk("lat_1_13", lat, 2);

    bad_vecs[0] = '{a: 6,  m: 9};
    bad_vecs[1] = '{a: 0,  m: 11};
    bad_vecs[2] = '{a: 5,  m: 8};
    bad_vecs[3] = '{a: 12, m: 11};
    bad_vecs[4] = '{a: 1,  m: 1};
    for (int i = 0; i < 5; i++) begin
      run(bad_vecs[i].a[7:0], bad_vecs[i].m[7:0], res, er, lat);
      chk("bad_err", er, 1);
      chk("bad_out", res, 0);
      chk("bad_done", done, 1);
    end

    // Start while busy is ignored
    @(negedge clock);
    start = 1'b1;
    a_in  = 8'd3;
    m_in  = 8'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    chk("ign_busy", busy, 1);
    start = 1'b1;
    a_in  = 8'd2;
    m_in  = 8'd7;
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
      if (done) got = 1'b1;
    end
    chk("ign_done", got, 1);
    chk("ign_out", out, 5);
    chk("ign_err", error, 0);

    // Asynchronous reset in the middle of RUN
    @(negedge clock);
    start = 1'b1;
    a_in  = 8'd7;
    m_in  = 8'd255;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_err", error, 0);
    chk("ar_out", out, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("ar_no_done", done, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    chk("ar_still_idle", done, 0);
    run(8'd4, 8'd9, res, er, lat);
    chk("inv_4_9", res, 7);
    chk("err_4_9", er, 0);

    // Sweep: all odd m up to 31 plus three large moduli
    for (int m = 3; m <= 31; m += 2) begin
      for (int a = 1; a < m; a++) begin
        run(a[7:0], m[7:0], res, er, lat);
        chk("sw_lat", (lat <= 34), 1);
        if (gcd(a, m) == 1) begin
          chk("sw_err", er, 0);
          chk("sw_inv", (a * int'(res)) % m, 1);
        end else begin
          chk("sw_err", er, 1);
          chk("sw_out", res, 0);
        end
      end
    end
    sweep_m[0] = 255;
    sweep_m[1] = 251;
    sweep_m[2] = 129;
    for (int k = 0; k < 3; k++) begin
      for (int a = 1; a < sweep_m[k]; a++) begin
        run(a[7:0], sweep_m[k][7:0], res, er, lat);
        chk("swl_lat", (lat <= 34), 1);
        if (gcd(a, sweep_m[k]) == 1) begin
          chk("swl_err", er, 0);
          chk("swl_inv", (a * int'(res)) % sweep_m[k], 1);
        end else begin
          chk("swl_err", er, 1);
          chk("swl_out", res, 0);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
